// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver: latches NDIGITS nibbles plus dp/enable,
// commits them only at frame boundaries, and scans one digit per SCAN_DIV cycles.
module seg7_scan_driver #(
    parameter int NDIGITS    = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [NDIGITS-1:0]     dp_in,
    input  logic [NDIGITS-1:0]     en_mask,
    input  logic                   blank_lz,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [NDIGITS-1:0]     an,
    output logic                   pending,
    output logic                   frame_tick
);

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [IW-1:0]      LAST_IDX  = IW'(NDIGITS - 1);
    localparam logic [DW-1:0]      TERM_CNT  = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]      PRE_CNT   = DW'(SCAN_DIV - 2);
    localparam logic [NDIGITS-1:0] ONE_HOT0  = NDIGITS'(1'b1);
    localparam logic [6:0]         SEG_OFF   = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic               DP_OFF    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NDIGITS-1:0] AN_OFF    = (ACTIVE_LOW != 0) ? {NDIGITS{1'b1}} : {NDIGITS{1'b0}};

    // Active-low segment code for one hex nibble (bit0=a ... bit6=g).
    function automatic logic [6:0] hex_al(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = 7'h40;
            4'h1:    code = 7'h79;
            4'h2:    code = 7'h24;
            4'h3:    code = 7'h30;
            4'h4:    code = 7'h19;
            4'h5:    code = 7'h12;
            4'h6:    code = 7'h02;
            4'h7:    code = 7'h78;
            4'h8:    code = 7'h00;
            4'h9:    code = 7'h10;
            4'hA:    code = 7'h08;
            4'hB:    code = 7'h03;
            4'hC:    code = 7'h46;
            4'hD:    code = 7'h21;
            4'hE:    code = 7'h06;
            4'hF:    code = 7'h0E;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    logic [DW-1:0]          div_cnt_r;
    logic [IW-1:0]          idx_r;
    logic                   frame_tick_r;
    logic                   pending_r;
    logic [4*NDIGITS-1:0]   disp_val_r, pend_val_r;
    logic [NDIGITS-1:0]     disp_dp_r, pend_dp_r;
    logic [NDIGITS-1:0]     disp_en_r, pend_en_r;
    logic [6:0]             seg_r;
    logic                   dp_r;
    logic [NDIGITS-1:0]     an_r;

    logic                   term_s;
    logic [NDIGITS-1:0]     lz_s;
    logic                   blank_s;
    logic [3:0]             nib_s;
    logic [6:0]             seg_al_s;
    logic                   dp_al_s;
    logic [NDIGITS-1:0]     an_al_s;

    assign term_s = (div_cnt_r == TERM_CNT);

    // Scan divider and digit index; frame_tick is pre-decoded so it is high in the wrap cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r    <= {DW{1'b0}};
            idx_r        <= {IW{1'b0}};
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= (div_cnt_r == PRE_CNT) && (idx_r == LAST_IDX);
            if (term_s) begin
                div_cnt_r <= {DW{1'b0}};
                idx_r     <= (idx_r == LAST_IDX) ? {IW{1'b0}} : idx_r + IW'(1);
            end else begin
                div_cnt_r <= div_cnt_r + DW'(1);
            end
        end
    end

    // Pending capture and frame-boundary commit; a load in the commit cycle bypasses pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r  <= 1'b0;
            pend_val_r <= {(4*NDIGITS){1'b0}};
            pend_dp_r  <= {NDIGITS{1'b0}};
            pend_en_r  <= {NDIGITS{1'b0}};
            disp_val_r <= {(4*NDIGITS){1'b0}};
            disp_dp_r  <= {NDIGITS{1'b0}};
            // Enables come up set so a freshly reset display shows zeros rather than going dark.
            disp_en_r  <= {NDIGITS{1'b1}};
        end else if (frame_tick_r) begin
            pending_r <= 1'b0;
            if (load) begin
                disp_val_r <= value;
                disp_dp_r  <= dp_in;
                disp_en_r  <= en_mask;
            end else if (pending_r) begin
                disp_val_r <= pend_val_r;
                disp_dp_r  <= pend_dp_r;
                disp_en_r  <= pend_en_r;
            end
        end else if (load) begin
            pending_r  <= 1'b1;
            pend_val_r <= value;
            pend_dp_r  <= dp_in;
            pend_en_r  <= en_mask;
        end
    end

    // Leading-zero mask, blanking and decode of the digit currently selected by idx.
    always_comb begin
        logic zeros_v;
        zeros_v = 1'b1;
        lz_s    = {NDIGITS{1'b0}};
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            zeros_v = zeros_v & (disp_val_r[4*i +: 4] == 4'h0);
            lz_s[i] = blank_lz & zeros_v & (i != 0);
        end
        nib_s   = disp_val_r[{idx_r, 2'b00} +: 4];
        blank_s = ~disp_en_r[idx_r] | lz_s[idx_r];
        if (blank_s) begin
            seg_al_s = 7'h7F;
            dp_al_s  = 1'b1;
            an_al_s  = {NDIGITS{1'b1}};
        end else begin
            seg_al_s = hex_al(nib_s);
            dp_al_s  = ~disp_dp_r[idx_r];
            an_al_s  = ~(ONE_HOT0 << idx_r);
        end
    end

    // Pin registers; the polarity parameter inverts seg, dp and an together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= SEG_OFF;
            dp_r  <= DP_OFF;
            an_r  <= AN_OFF;
        end else if (ACTIVE_LOW != 0) begin
            seg_r <= seg_al_s;
            dp_r  <= dp_al_s;
            an_r  <= an_al_s;
        end else begin
            seg_r <= ~seg_al_s;
            dp_r  <= ~dp_al_s;
            an_r  <= ~an_al_s;
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign an         = an_r;
    assign pending    = pending_r;
    assign frame_tick = frame_tick_r;

endmodule
